seq_magnitude_compare: RTL



---
 rtl/seq_magnitude_compare.sv | 130 +++++++++++++
 1 files changed

// File: rtl/seq_magnitude_compare.sv
// ============================================================================
// Module   : seq_magnitude_compare
// Brief    : Multi-beat eq/gt/lt comparator; operands stream MS chunk first.
//            Optional macro SIGNED_CMP_EN: MS chunk compared as two's complement.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_magnitude_compare #(
  parameter int WIDTH = 4,
  parameter int BEATS = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic             eq,
  output logic             gt,
  output logic             lt
);

  localparam int                CNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0]  C_LAST = CNT_W'(BEATS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMP  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             decided_q;
  logic             in_ready_q;
  logic             busy_q;
  logic             done_q;
  logic             eq_q;
  logic             gt_q;
  logic             lt_q;

  logic             w_accept;
  logic             w_chunk_gt;
  logic             w_chunk_lt;
  logic             w_chunk_ne;

  assign w_accept   = in_valid & in_ready_q;
  assign w_chunk_ne = (A != B);

`ifdef SIGNED_CMP_EN
  // Only the MS chunk carries the sign; lower chunks are plain magnitude.
  assign w_chunk_gt = (cnt_q == '0) ? ($signed(A) > $signed(B)) : (A > B);
  assign w_chunk_lt = (cnt_q == '0) ? ($signed(A) < $signed(B)) : (A < B);
`else
  assign w_chunk_gt = (A > B);
  assign w_chunk_lt = (A < B);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      decided_q  <= 1'b0;
      in_ready_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      eq_q       <= 1'b0;
      gt_q       <= 1'b0;
      lt_q       <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q    <= CMP;
            cnt_q      <= '0;
            decided_q  <= 1'b0;
            eq_q       <= 1'b0;
            gt_q       <= 1'b0;
            lt_q       <= 1'b0;
            in_ready_q <= 1'b1;
            busy_q     <= 1'b1;
          end
        end
        CMP: begin
          if (w_accept) begin
            if (!decided_q && w_chunk_ne) begin
              gt_q      <= w_chunk_gt;
              lt_q      <= w_chunk_lt;
              decided_q <= 1'b1;
            end
            // The final beat can itself be the deciding one, so fold it into eq.
            if (cnt_q == C_LAST) begin
              state_q    <= DONE;
              in_ready_q <= 1'b0;
              done_q     <= 1'b1;
              eq_q       <= ~decided_q & ~w_chunk_ne;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q    <= IDLE;
          in_ready_q <= 1'b0;
          busy_q     <= 1'b0;
          done_q     <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready = in_ready_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign eq       = eq_q;
  assign gt       = gt_q;
  assign lt       = lt_q;

endmodule

`default_nettype wire
